prng_arbiter: RTL
=================

# prng_arbiter

- Sequencer and arbiter sharing one 12-bit `random_generator` LFSR between two requesters (e.g. pixel-noise injector and timing-jitter source in the HDMI verification path).
- Per request, the block:
  - seeds the LFSR;
  - streams a requested number of words over a valid/ready handshake;
  - freezes the free-running LFSR under backpressure by reloading it each stalled cycle;
  - signals completion.
- Arbitration between the two requesters is round-robin.

## Interface
Parameters:
- LEN_W, 8, width of each burst length field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  2  per-requester request level, sampled only in IDLE
- req_len  in  2*LEN_W  burst lengths; bits [LEN_W-1:0] belong to req[0]
- seed_wr  in  2  per-requester seed write strobe
- seed_in  in  12  seed value written on seed_wr
- grant  out  2  one-hot, high from LOAD through DONE
- out_valid  out  1  random word valid
- out_data  out  12  random word; 0 when out_valid low
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- done  out  2  one-cycle pulse at end of burst
- lfsr_load  out  1  to LFSR load
- lfsr_seed  out  12  to LFSR seed; 0 when lfsr_load low
- lfsr_num  in  12  from LFSR rand_num

## Operation
- **Shared reset.** LFSR shares clk/rst.
- **Seed registers.**
  - Seed register reset values: seed0=12'hACE, seed1=12'h5A5.
  - seed_wr[i] writes seed_in into seed[i] in the cycle it is asserted.
  - Both strobes high writes both.
- **Start value.** Start value = seed[i] (or ctx[i], see Configuration).
  - 12'h000 is replaced by 12'h001, since a zero state locks up the LFSR.
- **IDLE.**
  - No req: stay.
  - One req: grant it.
  - Both: grant the requester not granted last. rr pointer resets to "last=1", so req[0] wins the first tie.
  - Latch the granted length.
  - Length 0: go directly to DONE; no words, no LFSR load.
  - Otherwise go to LOAD.
- **LOAD.** lfsr_load=1, lfsr_seed=start value; always go to RUN next.
- **RUN.**
  - out_valid=1, out_data=lfsr_num.
  - Accept: lfsr_load=0 (LFSR advances); count decrements. Last accept goes to DONE.
  - Stall: lfsr_load=1, lfsr_seed=lfsr_num, holding the LFSR state and out_data.
- **DONE.** done[i]=1, grant held; return to IDLE next cycle.
- **req behaviour.**
  - req is ignored outside IDLE.
  - Dropping req mid-burst does not abort it.
  - req still high after done is re-arbitrated normally.
- **seed_wr during a burst.** Updates the register immediately; takes effect on the next grant.
- **Reset mid-burst.** Immediate return to IDLE; all outputs, seeds, ctx and rr at reset values. No done pulse.

## Timing
- Output reset values: grant=0, out_valid=0, out_data=0, done=0, lfsr_load=0, lfsr_seed=0.
- Request latency:
  - req seen in IDLE at cycle T.
  - LOAD at T+1.
  - First out_valid at T+2.
- Burst completion:
  - Last accept at cycle T.
  - DONE at T+1.
  - IDLE at T+2.
  - Earliest next out_valid at T+4.
- Zero-stall bursts produce one word per cycle.
- done is registered state-decoded.
- out_data and lfsr_seed are combinational from state and lfsr_num.

## Configuration
- **PRNG_ARB_CTX_EN.**
  - Defined:
    - Per-requester context registers ctx[i] are added, reset to the seed reset values.
    - In DONE, ctx[granted] <= lfsr_num, the LFSR successor of the last accepted word.
    - Start value = ctx[i], so each requester sees an independent continuous sequence.
    - seed_wr[i] also writes ctx[i] and wins over a same-cycle DONE save.
  - Undefined:
    - No ctx registers.
    - Every grant restarts from seed[i].

## Test plan
- **Reset.** Assert rst mid-RUN → all outputs 0 asynchronously. After release, IDLE with no done pulse.
- **Single burst.** seed_wr[0] with 12'h001, req[0] len 3, out_ready=1 → out_data 001, 002, 004 on consecutive cycles starting T+2; done[0] one cycle after the third accept.
- **Stall freeze.** Seed 12'h800, len 2, out_ready low 5 cycles → out_data held at 800 with lfsr_load=1 each stalled cycle; then 800, 7F1.
- **Round-robin.** Both req high continuously, len 1 each → grants alternate 01, 10, 01, 10, with req[0] first after reset.
- **Zero guard.** Seed 12'h000, len 1 → word 12'h001. Length 0 → done after one cycle, no out_valid.
- **Context.** req[0] len 2 from seed 001 (001, 002), then req[1] burst, then req[0] len 1 → 004 with PRNG_ARB_CTX_EN, 001 without.

Source files
------------

// File: rtl/prng_arbiter.sv
// Round-robin sequencer sharing one 12-bit LFSR between two requesters.
// Optional build macro PRNG_ARB_CTX_EN adds per-requester continuation context.
module prng_arbiter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [1:0]         seed_wr,
  input  logic [11:0]        seed_in,
  output logic [1:0]         grant,
  output logic               out_valid,
  output logic [11:0]        out_data,
  input  logic               out_ready,
  output logic [1:0]         done,
  output logic               lfsr_load,
  output logic [11:0]        lfsr_seed,
  input  logic [11:0]        lfsr_num
);

  localparam int unsigned RW = 12;
  localparam logic [RW-1:0] SEED0_RST = 12'hACE;
  localparam logic [RW-1:0] SEED1_RST = 12'h5A5;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        gnt;
  logic [LEN_W-1:0]  cnt;
  logic              last;
  logic [RW-1:0]     seed [2];
  logic [1:0]        pick;
  logic [LEN_W-1:0]  pick_len;
  logic [RW-1:0]     base;
  logic [RW-1:0]     start;
  logic              accept;

  // Round-robin pick: on a tie, favour the requester not granted last
  assign pick     = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  assign pick_len = pick[1] ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

`ifdef PRNG_ARB_CTX_EN
  logic [RW-1:0] ctx [2];

  // Context tracks the successor of each requester's last word; seed writes win
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx[0] <= SEED0_RST;
      ctx[1] <= SEED1_RST;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (seed_wr[i]) begin
          ctx[i] <= seed_in;
        end else if (state == DONE && gnt[i]) begin
          ctx[i] <= lfsr_num;
        end
      end
    end
  end

  assign base = ctx[gnt[1]];
`else
  assign base = seed[gnt[1]];
`endif

  // All-zero is the LFSR lock-up state, so never load it
  assign start = (base == '0) ? RW'(1) : base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed[0] <= SEED0_RST;
      seed[1] <= SEED1_RST;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (seed_wr[i]) begin
          seed[i] <= seed_in;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stalls reload the LFSR with its own output so the word holds steady
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    lfsr_load = 1'b0;
    lfsr_seed = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = (pick_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        lfsr_seed = start;
        state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_data  = lfsr_num;
        if (out_ready) begin
          accept = 1'b1;
          if (cnt == LEN_W'(1)) begin
            state_nxt = DONE;
          end
        end else begin
          lfsr_load = 1'b1;
          lfsr_seed = lfsr_num;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant, burst counter and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= '0;
      cnt  <= '0;
      last <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          gnt <= pick;
          cnt <= pick_len;
          if (|req) begin
            last <= pick[1];
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        DONE: begin
          gnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign grant = gnt;
  assign done  = (state == DONE) ? gnt : 2'b00;

endmodule
